instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage wrapped around the combinational instruction memory.
- Owns the PC and drives the byte address to the memory. Captures the returned word, together with its PC, into a small prefetch FIFO.
- Presents instructions to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush all prefetched work.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  XLEN  byte address to instruction memory; equals the PC register.
- imem_inst  in  XLEN  instruction word, valid combinationally in the same cycle as imem_addr.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  XLEN  target PC.
- if_valid  out  1  FIFO head holds a valid instruction.
- if_ready  in  1  decoder accepts the head.
- if_inst  out  XLEN  head instruction.
- if_pc  out  XLEN  PC of the head instruction.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; FIFO rd_ptr=0, wr_ptr=0, count=0.
  - if_valid=0, if_inst=0, if_pc=0, imem_addr=RESET_PC.
  - Reset mid-operation discards all FIFO contents immediately.
- pop = if_valid & if_ready.
- push = !redirect_valid & (count<FIFO_DEPTH | pop).
  - A full FIFO with a same-cycle pop still accepts a push; count is unchanged.
- On push: write {pc, imem_inst} at wr_ptr, then pc <= pc+4.
  - The add is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- Redirect (priority over push):
  - Next edge: pc <= {redirect_pc[XLEN-1:2], 2'b00}; count=0; rd_ptr=wr_ptr=0.
  - No push occurs that cycle.
  - A pop in the redirect cycle still counts as accepted by the decoder; the flush then drops everything else.
- FIFO pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH.
  - if_valid = (count!=0).
- if_inst/if_pc are driven from the head entry.
  - When if_valid=0 they read 0; this is a bubble and the decoder must treat it as a NOP.
- Latency:
  - An instruction at pc is visible at the decoder one cycle after pc is presented (FIFO empty case).
  - After a redirect, the first target instruction has if_valid=1 two edges after redirect_valid is sampled.
- Throughput: one instruction per cycle when if_ready is held high.
- Stall (if_ready=0): the FIFO fills to FIFO_DEPTH, then pc holds and imem_addr stays stable.
- Simultaneous push and pop with count=0: the pushed entry becomes the head next cycle (no bypass).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetched (32) and perf_flushed (32).
  - perf_fetched increments on every push.
  - perf_flushed adds the count of entries discarded on each redirect, i.e. (count - pop) at that edge.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN.
  - INST_NOP = 32'h0000_0013.
  - Default RESET_PC.
  - Packed struct fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo (parameterised by depth and entry type) holds:
  - Storage, pointers and count.
  - push/pop/flush inputs; full/empty/head outputs.
- instr_fetch_unit keeps the PC register, push/redirect arbitration and the optional counters.

Test Plan:
- Reset release with RESET_PC=0 and if_ready=1 -> if_pc sequence 0,4,8,12 on consecutive cycles; if_inst matches the memory words; imem_addr leads if_pc by one cycle.
- Hold if_ready=0 for 10 cycles from reset -> count stops at 4 and imem_addr freezes at 16. Raise if_ready -> pcs 0,4,8,12,16 delivered with no loss or duplicate.
- With FIFO full and if_ready=1 -> push and pop in the same cycle; count stays 4; the pc stream stays continuous.
- redirect_valid=1, redirect_pc=32'h0000_005E while 3 entries are buffered -> next cycle if_valid=0. The following cycle if_pc=32'h0000_005C; old entries are never presented. With FETCH_PERF_CNT_EN, perf_flushed=3 (or 2 if a pop occurred that cycle).
- Redirect to 32'hFFFF_FFFC -> if_pc 32'hFFFF_FFFC then 32'h0000_0000.
- Assert rst_n=0 asynchronously mid-stream between clock edges -> if_valid drops and imem_addr=RESET_PC immediately, without waiting for a clock edge. On release, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, execute redirect and decoder handshake.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_inst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;

  // Fetch unit side
  modport master (
    output imem_addr, if_valid, if_inst, if_pc,
    input  imem_inst, redirect_valid, redirect_pc, if_ready
  );

  // Memory / execute / decoder side
  modport slave (
    input  imem_addr, if_valid, if_inst, if_pc,
    output imem_inst, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with flush; head reads as all-zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth   = 4,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  entry_t          wdata_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o,
  output entry_t          head_o
);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q,  count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i)      count_d = count_q + CntW'(1);
      else if (!push_i && pop_i) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? entry_t'('0) : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, push/redirect arbitration and prefetch FIFO.
// Optional perf_fetched/perf_flushed counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed,
`endif
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop, full, empty;
  logic [CntW-1:0] count;
  fetch_entry_t    head, wdata;

  assign pop   = bus.if_valid & bus.if_ready;
  // A full FIFO can still accept when its head leaves in the same cycle.
  assign push  = !bus.redirect_valid & (!full | pop);
  assign wdata = '{pc: pc_q, inst: bus.imem_inst};

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (push)          pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_fifo #(
    .Depth   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .wdata_i (wdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = !empty;
  assign bus.if_inst   = head.inst;
  assign bus.if_pc     = head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     fetched_q, fetched_d;
  logic [31:0]     flushed_q, flushed_d;
  logic [32:0]     flushed_sum;
  logic [CntW-1:0] dropped;

  // Entries lost on a redirect exclude the one the decoder takes that cycle.
  assign dropped     = count - CntW'(pop);
  assign flushed_sum = {1'b0, flushed_q} + 33'(dropped);

  always_comb begin
    fetched_d = fetched_q;
    flushed_d = flushed_q;
    if (push && fetched_q != 32'hFFFF_FFFF) fetched_d = fetched_q + 32'd1;
    if (bus.redirect_valid) flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a queue-based fetch model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  instr_fetch_unit #(
    .RESET_PC   (RstPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_inst = mem_word(bus.imem_addr);

  // Reference model: what the decoder should see, as a plain queue of fetched words.
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_flushed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_inst.delete();
    m_pc      = RstPc;
    m_fetched = 0;
    m_flushed = 0;
  endtask

  task automatic compare_outputs();
    logic has;
    has = (q_pc.size() != 0);
    check("if_valid", 32'(bus.if_valid), 32'(has));
    check("if_pc", bus.if_pc, has ? q_pc[0] : 32'h0);
    check("if_inst", bus.if_inst, has ? q_inst[0] : 32'h0);
    check("imem_addr", bus.imem_addr, m_pc);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_flushed", perf_flushed, m_flushed);
`endif
  endtask

  // Called at a falling edge: compare, drive inputs, advance model over the next rising edge.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    int  n;
    bit  pop, push;
    compare_outputs();
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    n    = q_pc.size();
    pop  = (n != 0) && rdy;
    push = !rv && (n < Depth || pop);
    if (rv) begin
      m_flushed = m_flushed + 32'(n - int'(pop));
      q_pc.delete();
      q_inst.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (push) begin
        q_pc.push_back(m_pc);
        q_inst.push_back(mem_word(m_pc));
        m_pc      = m_pc + 32'd4;
        m_fetched = m_fetched + 32'd1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.if_valid), 32'h0);
    check("rst_addr", bus.imem_addr, RstPc);
    check("rst_inst", bus.if_inst, 32'h0);
    rst_n = 1'b1;

    // Streaming from reset: pcs 0,4,8,12,... one per cycle.
    repeat (6) step(1'b0, '0, 1'b1);

    // Asynchronous reset between edges takes effect without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.if_valid), 32'h0);
    check("async_addr", bus.imem_addr, RstPc);
    check("async_pc", bus.if_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Stall from reset: FIFO fills to Depth and the PC freezes at 16.
    repeat (10) step(1'b0, '0, 1'b0);
    check("stall_addr", bus.imem_addr, 32'd16);
    // Drain with concurrent refill while full.
    repeat (8) step(1'b0, '0, 1'b1);

    // Buffer three entries behind a fresh target, then redirect to 0x5E.
    step(1'b1, 32'h0000_0100, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    step(1'b1, 32'h0000_005E, 1'b0);
    check("redir_bubble", 32'(bus.if_valid), 32'h0);
    repeat (3) step(1'b0, '0, 1'b1);

    // Redirect with a same-cycle pop, then PC wrap at the top of memory.
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      step(rv, rpc, ($urandom_range(0, 9) < 7));
    end
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
